// File: rtl/logic_share_arb_pkg.sv
// Shared definitions for the round-robin arbitrated bitwise logic unit:
// opcode values and the arbiter FSM state encoding.
package logic_share_arb_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/logic_share_arb_logic_unit.sv
// Purely combinational bitwise unit shared by all requesters.
module logic_unit
   import logic_share_arb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   op,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_share_arb.sv
// Round-robin arbiter feeding one shared logic unit; one transaction in flight,
// request accepted in IDLE, result computed in EXEC, held in RESP until taken.
module logic_share_arb
   import logic_share_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int W    = 8,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; the producer holds valid and payload until then.

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic [W-1:0]   cap_a;
   logic [W-1:0]   cap_b;
   logic [1:0]     cap_op;
   logic [IDW-1:0] cap_id;
   logic [W-1:0]   unit_y;

   logic           found;
   int             win_i;
   logic [IDW-1:0] win_id;

   // Search starts one past the last winner so each requester waits at most
   // NREQ-1 other grants.
   always_comb begin
      found  = 1'b0;
      win_i  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(last_grant) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win_i = idx;
         end
      end
      win_id = win_i[IDW-1:0];
   end

   // Only depends on state and req_valid, so rsp_ready never reaches it.
   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && found) begin
         req_ready[win_i] = 1'b1;
      end
   end

   logic_unit #(.W(W)) u_logic_unit (
      .a  (cap_a),
      .b  (cap_b),
      .op (cap_op),
      .y  (unit_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= IDW'(NREQ - 1);
         cap_a      <= '0;
         cap_b      <= '0;
         cap_op     <= '0;
         cap_id     <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  cap_a      <= req_a[win_i*W +: W];
                  cap_b      <= req_b[win_i*W +: W];
                  cap_op     <= req_op[win_i*2 +: 2];
                  cap_id     <= win_id;
                  last_grant <= win_id;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data  <= unit_y;
               rsp_id    <= cap_id;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
